// File: rtl/cache_bus_responder_if.sv
// ============================================================================
// Module      : cache_bus_responder_if
// Description : L2-cache <-> shared-bus responder signal bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cache_bus_responder_if #(
  parameter int CNT_W = 16
) ();
  logic             bus_valid;
  logic [2:0]       bus_op;
  logic [31:0]      bus_addr;
  logic             bus_ready;
  logic             snoop_valid;
  logic [1:0]       snoop_C;
  logic             done;
  logic             fill_valid;
  logic             op_err;
  logic [CNT_W-1:0] dram_rd_cntr;
  logic [CNT_W-1:0] dram_wr_cntr;

  modport master (
    output bus_valid, bus_op, bus_addr,
    input  bus_ready, snoop_valid, snoop_C, done, fill_valid, op_err,
           dram_rd_cntr, dram_wr_cntr
  );

  modport slave (
    input  bus_valid, bus_op, bus_addr,
    output bus_ready, snoop_valid, snoop_C, done, fill_valid, op_err,
           dram_rd_cntr, dram_wr_cntr
  );
endinterface

`default_nettype wire

// File: rtl/cache_bus_responder.sv
// ============================================================================
// Module      : cache_bus_responder
// Description : Shared-bus model for the L2 cache: snoop result, modelled
//               completion latency and DRAM transaction counters.
//               Optional trace output: define CACHE_BUS_TRACE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cache_bus_responder #(
  parameter int DRAM_LAT = 4,
  parameter int XFER_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  wire logic             clk,
  input  wire logic             rstb_comb,
  cache_bus_responder_if.slave  bus
);

  localparam logic [2:0]       c_OP_READ   = 3'd1;
  localparam logic [2:0]       c_OP_WRITE  = 3'd2;
  localparam logic [2:0]       c_OP_INV    = 3'd3;
  localparam logic [2:0]       c_OP_RWIM   = 3'd4;
  localparam logic [7:0]       c_DRAM_WAIT = 8'(DRAM_LAT - 1);
  localparam logic [7:0]       c_XFER_WAIT = 8'(XFER_LAT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SNOOP    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e           r_state;
  state_e           w_next;
  logic [7:0]       r_lat_cnt;
  logic [7:0]       w_lat_cnt_next;
  logic [2:0]       r_op;
  logic [31:0]      r_addr;
  logic [1:0]       r_snoop_c;
  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic             w_rd_inc;
  logic             w_wr_inc;
  logic             w_in_legal;
  logic             w_op_legal;
  logic             w_fill_op;
  logic [1:0]       w_snoop_c;
  logic             w_hitm;
  logic             w_addr_unused;

  assign w_in_legal = (bus.bus_op != 3'd0) && (bus.bus_op <= c_OP_RWIM);
  assign w_op_legal = (r_op != 3'd0) && (r_op <= c_OP_RWIM);
  assign w_fill_op  = (r_op == c_OP_READ) || (r_op == c_OP_RWIM);
  assign w_snoop_c  = r_addr[1] ? 2'b10 : {1'b0, r_addr[0]};
  assign w_hitm     = (w_snoop_c == 2'b01);
  // Upper address bits are kept for the optional trace only.
  assign w_addr_unused = ^r_addr[31:2];

  always_comb begin
    w_next           = r_state;
    w_lat_cnt_next   = r_lat_cnt;
    w_rd_inc         = 1'b0;
    w_wr_inc         = 1'b0;
    bus.bus_ready    = 1'b0;
    bus.snoop_valid  = 1'b0;
    bus.done         = 1'b0;
    bus.fill_valid   = 1'b0;
    bus.op_err       = 1'b0;
    bus.snoop_C      = r_snoop_c;
    bus.dram_rd_cntr = r_rd_cnt;
    bus.dram_wr_cntr = r_wr_cnt;
    case (r_state)
      ST_IDLE: begin
        bus.bus_ready = 1'b1;
        if (bus.bus_valid) begin
          w_next = w_in_legal ? ST_SNOOP : ST_DONE;
        end
      end
      ST_SNOOP: begin
        bus.snoop_valid = 1'b1;
        bus.snoop_C     = w_snoop_c;
        if (r_op == c_OP_INV) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_MEM_WAIT;
          // A modified line elsewhere is supplied cache-to-cache and flushed to DRAM.
          if (w_fill_op && w_hitm) begin
            w_lat_cnt_next = c_XFER_WAIT;
            w_wr_inc       = 1'b1;
          end else begin
            w_lat_cnt_next = c_DRAM_WAIT;
            w_rd_inc       = w_fill_op;
            w_wr_inc       = (r_op == c_OP_WRITE);
          end
        end
      end
      ST_MEM_WAIT: begin
        if (r_lat_cnt == 8'd0) begin
          w_next = ST_DONE;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 8'd1;
        end
      end
      ST_DONE: begin
        bus.done       = 1'b1;
        bus.fill_valid = w_fill_op;
        bus.op_err     = ~w_op_legal;
        w_next         = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb_comb) begin
    if (!rstb_comb) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= 8'd0;
      r_op      <= 3'd0;
      r_addr    <= 32'd0;
      r_snoop_c <= 2'b00;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_lat_cnt <= w_lat_cnt_next;
      if (r_state == ST_IDLE && bus.bus_valid) begin
        r_op   <= bus.bus_op;
        r_addr <= bus.bus_addr;
      end
      if (r_state == ST_SNOOP) begin
        r_snoop_c <= w_snoop_c;
      end
      if (w_rd_inc && r_rd_cnt != c_CNT_MAX) begin
        r_rd_cnt <= r_rd_cnt + c_CNT_ONE;
      end
      if (w_wr_inc && r_wr_cnt != c_CNT_MAX) begin
        r_wr_cnt <= r_wr_cnt + c_CNT_ONE;
      end
    end
  end

`ifdef CACHE_BUS_TRACE_EN
  function automatic string op_name(input logic [2:0] op);
    case (op)
      c_OP_READ:  return "READ";
      c_OP_WRITE: return "WRITE";
      c_OP_INV:   return "INVALIDATE";
      default:    return "RWIM";
    endcase
  endfunction

  function automatic string snoop_name(input logic [1:0] c);
    case (c)
      2'b00:   return "HIT";
      2'b01:   return "HITM";
      default: return "NOHIT";
    endcase
  endfunction

  always @(posedge clk) begin
    if (rstb_comb && r_state == ST_SNOOP) begin
      $display("BusOp: %s, Address: %08h, Snoop Result: %s",
               op_name(r_op), r_addr, snoop_name(w_snoop_c));
    end
    if (rstb_comb && r_state == ST_DONE && !w_op_legal) begin
      $display("BusOp: ILLEGAL %0d", r_op);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_bus_responder.sv
// ============================================================================
// Module      : tb_cache_bus_responder
// Description : Self-checking bench for cache_bus_responder (randomized ops
//               against a latency/counter reference model).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_bus_responder;

  localparam int DRAM_LAT = 4;
  localparam int XFER_LAT = 2;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rstb_comb = 1'b0;
  always #5 clk = ~clk;

  cache_bus_responder_if #(.CNT_W(CNT_W)) bus_if ();

  cache_bus_responder #(
    .DRAM_LAT (DRAM_LAT),
    .XFER_LAT (XFER_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rstb_comb (rstb_comb),
    .bus       (bus_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Observations from the last run_op
  int         obs_snoop_k, obs_snoop_cnt, obs_done_k;
  logic [1:0] obs_c;
  logic       obs_fill, obs_err, obs_ready0, obs_ready_after, obs_done_after;

  // Reference model state
  int         exp_rd, exp_wr;
  logic [1:0] exp_last_c;

  function automatic void model_op(input logic [2:0] op, input logic [31:0] a,
                                   output int lat, output logic snp, output logic [1:0] c,
                                   output logic fill, output logic err,
                                   output int d_rd, output int d_wr);
    logic is_fill;
    c = (a[1:0] == 2'b00) ? 2'b00 : (a[1:0] == 2'b01) ? 2'b01 : 2'b10;
    is_fill = (op == 3'd1) || (op == 3'd4);
    d_rd = 0; d_wr = 0;
    snp = (op >= 3'd1 && op <= 3'd4);
    err = !snp;
    fill = is_fill;
    if (!snp)             lat = 1;
    else if (op == 3'd3)  lat = 2;
    else if (is_fill && c == 2'b01) begin lat = 2 + XFER_LAT; d_wr = 1; end
    else begin
      lat = 2 + DRAM_LAT;
      if (is_fill) d_rd = 1;
      if (op == 3'd2) d_wr = 1;
    end
  endfunction

  task automatic apply_reset();
    bus_if.bus_valid = 1'b0;
    @(negedge clk);
    rstb_comb = 1'b0;
    repeat (2) @(negedge clk);
    rstb_comb = 1'b1;
    exp_rd = 0; exp_wr = 0; exp_last_c = 2'b00;
  endtask

  // Starts at a negedge with the DUT idle; ends at the negedge after done.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr);
    obs_snoop_k = 0; obs_snoop_cnt = 0; obs_done_k = 0;
    obs_c = 2'b00; obs_fill = 1'b0; obs_err = 1'b0;
    bus_if.bus_valid = 1'b1;
    bus_if.bus_op    = op;
    bus_if.bus_addr  = addr;
    obs_ready0 = bus_if.bus_ready;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus_if.snoop_valid) begin
        obs_snoop_cnt++;
        if (obs_snoop_k == 0) begin obs_snoop_k = k; obs_c = bus_if.snoop_C; end
      end
      bus_if.bus_valid = 1'($urandom_range(0, 1));
      bus_if.bus_op    = 3'($urandom_range(0, 7));
      bus_if.bus_addr  = $urandom;
      if (bus_if.done) begin
        obs_done_k = k; obs_fill = bus_if.fill_valid; obs_err = bus_if.op_err;
        bus_if.bus_valid = 1'b0;
        break;
      end
    end
    bus_if.bus_valid = 1'b0;
    @(negedge clk);
    obs_ready_after = bus_if.bus_ready;
    obs_done_after  = bus_if.done;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({bus_if.bus_ready, bus_if.snoop_valid, bus_if.snoop_C, bus_if.done,
         bus_if.fill_valid, bus_if.op_err} !== 7'b1000000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 1000000", {bus_if.bus_ready,
               bus_if.snoop_valid, bus_if.snoop_C, bus_if.done, bus_if.fill_valid, bus_if.op_err});
    end
    n_vec++;
    if (bus_if.dram_rd_cntr !== 4'd0 || bus_if.dram_wr_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL reset_counters: got rd=%0d wr=%0d, expected 0/0", bus_if.dram_rd_cntr, bus_if.dram_wr_cntr);
    end
  endtask

  task automatic test_read();
    apply_reset();
    run_op(3'd1, 32'h0000_1002);
    n_vec++;
    if (obs_snoop_k !== 1 || obs_c !== 2'b10) begin
      n_err++;
      $display("FAIL read_snoop: got k=%0d C=%b, expected k=1 C=10", obs_snoop_k, obs_c);
    end
    n_vec++;
    if (obs_done_k !== 6 || obs_fill !== 1'b1 || obs_err !== 1'b0) begin
      n_err++;
      $display("FAIL read_done: got k=%0d fill=%b err=%b, expected k=6 fill=1 err=0", obs_done_k, obs_fill, obs_err);
    end
    n_vec++;
    if (bus_if.dram_rd_cntr !== 4'd1 || bus_if.dram_wr_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL read_counters: got rd=%0d wr=%0d, expected 1/0", bus_if.dram_rd_cntr, bus_if.dram_wr_cntr);
    end
    n_vec++;
    if (obs_ready_after !== 1'b1 || obs_done_after !== 1'b0) begin
      n_err++;
      $display("FAIL read_return_idle: got ready=%b done=%b, expected 1/0", obs_ready_after, obs_done_after);
    end
  endtask

  task automatic test_rwim_hitm();
    apply_reset();
    run_op(3'd4, 32'h0000_2001);
    n_vec++;
    if (obs_snoop_k !== 1 || obs_c !== 2'b01) begin
      n_err++;
      $display("FAIL rwim_snoop: got k=%0d C=%b, expected k=1 C=01", obs_snoop_k, obs_c);
    end
    n_vec++;
    if (obs_done_k !== 4 || obs_fill !== 1'b1) begin
      n_err++;
      $display("FAIL rwim_done: got k=%0d fill=%b, expected k=4 fill=1", obs_done_k, obs_fill);
    end
    n_vec++;
    if (bus_if.dram_rd_cntr !== 4'd0 || bus_if.dram_wr_cntr !== 4'd1) begin
      n_err++;
      $display("FAIL rwim_counters: got rd=%0d wr=%0d, expected 0/1", bus_if.dram_rd_cntr, bus_if.dram_wr_cntr);
    end
  endtask

  task automatic test_back_to_back();
    int done_k;
    apply_reset();
    bus_if.bus_valid = 1'b1;
    bus_if.bus_op    = 3'd3;
    bus_if.bus_addr  = 32'h0000_3000;
    @(negedge clk);
    n_vec++;
    if (bus_if.snoop_valid !== 1'b1 || bus_if.snoop_C !== 2'b00) begin
      n_err++;
      $display("FAIL inv_snoop: got sv=%b C=%b, expected 1/00", bus_if.snoop_valid, bus_if.snoop_C);
    end
    bus_if.bus_op   = 3'd2;
    bus_if.bus_addr = 32'h0000_4000;
    @(negedge clk);
    n_vec++;
    if (bus_if.done !== 1'b1 || bus_if.fill_valid !== 1'b0 ||
        bus_if.dram_rd_cntr !== 4'd0 || bus_if.dram_wr_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL inv_done: got done=%b fill=%b rd=%0d wr=%0d, expected 1/0/0/0",
               bus_if.done, bus_if.fill_valid, bus_if.dram_rd_cntr, bus_if.dram_wr_cntr);
    end
    @(negedge clk);
    n_vec++;
    if (bus_if.bus_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: got %b, expected 1", bus_if.bus_ready);
    end
    @(negedge clk);
    n_vec++;
    if (bus_if.snoop_valid !== 1'b1 || bus_if.snoop_C !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_accept: got sv=%b C=%b, expected 1/00", bus_if.snoop_valid, bus_if.snoop_C);
    end
    bus_if.bus_valid = 1'b0;
    done_k = 0;
    for (int k = 5; k <= 40; k++) begin
      @(negedge clk);
      if (bus_if.done) begin done_k = k; break; end
    end
    n_vec++;
    if (done_k !== 9 || bus_if.dram_wr_cntr !== 4'd1 || bus_if.dram_rd_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL b2b_write_done: got k=%0d wr=%0d rd=%0d, expected 9/1/0",
               done_k, bus_if.dram_wr_cntr, bus_if.dram_rd_cntr);
    end
    @(negedge clk);
  endtask

  task automatic test_reserved();
    apply_reset();
    run_op(3'd6, 32'hDEAD_BEEF);
    n_vec++;
    if (obs_done_k !== 1 || obs_err !== 1'b1 || obs_fill !== 1'b0 || obs_snoop_cnt !== 0) begin
      n_err++;
      $display("FAIL reserved_op: got k=%0d err=%b fill=%b snoops=%0d, expected 1/1/0/0",
               obs_done_k, obs_err, obs_fill, obs_snoop_cnt);
    end
    n_vec++;
    if (bus_if.dram_rd_cntr !== 4'd0 || bus_if.dram_wr_cntr !== 4'd0 || bus_if.snoop_C !== 2'b00) begin
      n_err++;
      $display("FAIL reserved_state: got rd=%0d wr=%0d C=%b, expected 0/0/00",
               bus_if.dram_rd_cntr, bus_if.dram_wr_cntr, bus_if.snoop_C);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    run_op(3'd2, 32'h0000_0010);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_op    = 3'd1;
    bus_if.bus_addr  = 32'h0000_1002;
    @(negedge clk);
    bus_if.bus_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus_if.bus_ready !== 1'b0 || bus_if.dram_wr_cntr !== 4'd1) begin
      n_err++;
      $display("FAIL mid_op_busy: got ready=%b wr=%0d, expected 0/1", bus_if.bus_ready, bus_if.dram_wr_cntr);
    end
    #2 rstb_comb = 1'b0;
    #1;
    n_vec++;
    if (bus_if.bus_ready !== 1'b1 || bus_if.done !== 1'b0 ||
        bus_if.dram_rd_cntr !== 4'd0 || bus_if.dram_wr_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL mid_op_reset: got ready=%b done=%b rd=%0d wr=%0d, expected 1/0/0/0",
               bus_if.bus_ready, bus_if.done, bus_if.dram_rd_cntr, bus_if.dram_wr_cntr);
    end
    @(negedge clk);
    rstb_comb = 1'b1;
    run_op(3'd1, 32'h0000_1002);
    n_vec++;
    if (obs_done_k !== 6 || obs_fill !== 1'b1 || bus_if.dram_rd_cntr !== 4'd1 || bus_if.dram_wr_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL post_reset_read: got k=%0d fill=%b rd=%0d wr=%0d, expected 6/1/1/0",
               obs_done_k, obs_fill, bus_if.dram_rd_cntr, bus_if.dram_wr_cntr);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      run_op(3'd2, $urandom);
      if (i == 14) begin
        n_vec++;
        if (bus_if.dram_wr_cntr !== 4'd15) begin
          n_err++;
          $display("FAIL sat_reach: got %0d, expected 15", bus_if.dram_wr_cntr);
        end
      end
    end
    n_vec++;
    if (bus_if.dram_wr_cntr !== 4'd15 || bus_if.dram_rd_cntr !== 4'd0) begin
      n_err++;
      $display("FAIL sat_hold: got wr=%0d rd=%0d, expected 15/0", bus_if.dram_wr_cntr, bus_if.dram_rd_cntr);
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] addr;
    int          lat, d_rd, d_wr;
    logic        snp, fill, err;
    logic [1:0]  c;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      op   = 3'($urandom_range(0, 7));
      addr = $urandom;
      model_op(op, addr, lat, snp, c, fill, err, d_rd, d_wr);
      run_op(op, addr);
      exp_rd = (exp_rd + d_rd > CNT_MAX) ? CNT_MAX : exp_rd + d_rd;
      exp_wr = (exp_wr + d_wr > CNT_MAX) ? CNT_MAX : exp_wr + d_wr;
      if (snp) exp_last_c = c;
      n_vec++;
      if (obs_ready0 !== 1'b1 || obs_done_k !== lat || obs_fill !== fill || obs_err !== err) begin
        n_err++;
        $display("FAIL rand_done op=%0d addr=%08h: got rdy=%b k=%0d fill=%b err=%b, expected 1/%0d/%b/%b",
                 op, addr, obs_ready0, obs_done_k, obs_fill, obs_err, lat, fill, err);
      end
      n_vec++;
      if (obs_snoop_cnt !== (snp ? 1 : 0) || (snp && (obs_snoop_k !== 1 || obs_c !== c))) begin
        n_err++;
        $display("FAIL rand_snoop op=%0d addr=%08h: got n=%0d k=%0d C=%b, expected n=%0d C=%b",
                 op, addr, obs_snoop_cnt, obs_snoop_k, obs_c, snp ? 1 : 0, c);
      end
      n_vec++;
      if (bus_if.dram_rd_cntr !== 4'(exp_rd) || bus_if.dram_wr_cntr !== 4'(exp_wr) ||
          bus_if.snoop_C !== exp_last_c || obs_ready_after !== 1'b1) begin
        n_err++;
        $display("FAIL rand_state op=%0d: got rd=%0d wr=%0d C=%b rdy=%b, expected %0d/%0d/%b/1",
                 op, bus_if.dram_rd_cntr, bus_if.dram_wr_cntr, bus_if.snoop_C, obs_ready_after,
                 exp_rd, exp_wr, exp_last_c);
      end
    end
  endtask

  initial begin
    bus_if.bus_valid = 1'b0;
    bus_if.bus_op    = 3'd0;
    bus_if.bus_addr  = 32'd0;
    test_reset();
    test_read();
    test_rwim_hitm();
    test_back_to_back();
    test_reserved();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_bus_responder.md
Name: cache_bus_responder

Overview:
- Models the shared-bus side seen by the L2 cache: other caches' snoop responses plus the DRAM/memory controller.
- Accepts one bus operation at a time from the L2 cache: READ, WRITE, INVALIDATE or RWIM.
- Returns the 2-bit snoop result C (00 HIT, 01 HITM, 1x NOHIT), then a completion after a modelled latency.
- Keeps DRAM read/write transaction counters for the bench.

Parameters:
- DRAM_LAT, 4, DRAM access latency in MEM_WAIT cycles; legal range 1..255.
- XFER_LAT, 2, cache-to-cache transfer latency when snoop result is HITM; legal range 1..255.
- CNT_W, 16, width of the DRAM counters.

Ports:
- clk  input  1  clock.
- rstb_comb  input  1  reset; asynchronous, active-low.
- bus_valid  input  1  operation request from the L2 cache.
- bus_op  input  3  1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM; 0 and 5..7 reserved.
- bus_addr  input  32  line address of the operation.
- bus_ready  output  1  high only in IDLE; accept = bus_valid & bus_ready.
- snoop_valid  output  1  one-cycle strobe qualifying snoop_C.
- snoop_C  output  2  snoop result.
- done  output  1  one-cycle completion strobe.
- fill_valid  output  1  with done: line data returned (READ/RWIM only).
- op_err  output  1  with done: reserved opcode was accepted.
- dram_rd_cntr  output  CNT_W  DRAM reads performed.
- dram_wr_cntr  output  CNT_W  DRAM writes performed.

Behaviour:
- Reset values: all outputs 0 except bus_ready = 1. FSM state = IDLE, latency counter 0, captured op/addr cleared.
- FSM states: IDLE, SNOOP, MEM_WAIT, DONE.
- IDLE, on accept at edge T0:
  - Register bus_op and bus_addr.
  - Legal op -> SNOOP; reserved op -> DONE with op_err.
- SNOOP (cycle after T0):
  - snoop_valid = 1; snoop_C = captured addr[1:0] mapped 00->00, 01->01, 10/11->10.
  - INVALIDATE -> DONE.
  - READ/RWIM with HITM -> MEM_WAIT, counter loaded with XFER_LAT-1.
  - All other legal cases -> MEM_WAIT, counter loaded with DRAM_LAT-1.
- MEM_WAIT:
  - Decrements each cycle; leaves to DONE on the cycle the counter is 0.
  - Occupies exactly the loaded latency in cycles.
- DONE: one cycle.
  - done = 1.
  - fill_valid = 1 for READ/RWIM.
  - op_err = 1 for reserved ops.
  - Next state IDLE.
- Latency, accept to done: INVALIDATE 2 cycles; HITM read 2+XFER_LAT; other ops 2+DRAM_LAT; reserved 1. bus_ready returns the cycle after done.
- Counters, updated on the SNOOP->MEM_WAIT edge:
  - READ/RWIM with C != HITM: dram_rd_cntr +1.
  - WRITE: dram_wr_cntr +1.
  - READ/RWIM with HITM: dram_wr_cntr +1 (snooper flushes to memory); no DRAM read counted.
  - Both counters saturate at all-ones, no wrap.
- bus_valid/bus_op/bus_addr are ignored outside IDLE. No queueing: a requester holding bus_valid high is accepted on the first IDLE cycle.
- bus_op/bus_addr changes after accept do not affect the transaction in flight.
- snoop_C holds its last value when snoop_valid = 0.
- Reset mid-operation: immediate return to IDLE, strobes cleared, counters zeroed. No completion for the aborted op.

Optional Feature:
- Macro CACHE_BUS_TRACE_EN.
- Defined: simulation-only $display at the SNOOP cycle, format "BusOp: <op name>, Address: <8-digit hex>, Snoop Result: <HIT|HITM|NOHIT>". Reserved ops print at DONE as "BusOp: ILLEGAL <code>".
- Not defined: no display code compiled; identical cycle behaviour and ports.

Test Plan:
- Reset mid-MEM_WAIT of a READ -> immediate IDLE, bus_ready=1, counters 0. Next READ completes normally.
- READ, addr 0x0000_1002, DRAM_LAT=4 -> snoop_C=10 at T0+1; done=1, fill_valid=1 at T0+6; dram_rd_cntr=1.
- RWIM, addr 0x0000_2001, XFER_LAT=2 -> snoop_C=01; done at T0+4 with fill_valid=1; dram_wr_cntr=1, dram_rd_cntr=0.
- INVALIDATE, addr 0x0000_3000 -> snoop_C=00 at T0+1, done at T0+2, fill_valid=0, counters unchanged. Then a back-to-back WRITE held valid is accepted at T0+3.
- bus_op=6 -> done=1 and op_err=1 at T0+1, snoop_valid never asserted, counters unchanged.
- CNT_W=4, 17 WRITEs -> dram_wr_cntr stops at 15.
